vram_read_arbiter: RTL and testbench

- Shares the single videoram read port (12-bit word address, 32-bit data) between two requesters.
  - Port 0: display scanout, high priority.
  - Port 1: barcode decoder / frame analysis, low priority.
- Issues at most one read per cycle to the on-chip memory and tags each read with its requester ID.
- Routes returned data back to the correct requester after the fixed memory read latency.
- Sits between the requesters and the videoram slave of the NIOS system, in the sys_clk domain.

---
 rtl/vram_arb_pkg.sv | 14 +
 rtl/vram_tag_pipe.sv | 27 ++
 rtl/vram_read_arbiter.sv | 105 ++++++++++
 tb/tb_vram_read_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the videoram read arbiter.
package vram_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } vram_tag_t;

  localparam logic [11:0] VRAM_DEFAULT_ADDR = '0;

endpackage

// File: rtl/vram_tag_pipe.sv
// Fixed-depth shift register of read tags, matched to the videoram read latency.
module vram_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      clear,
  input  vram_tag_t tag_in,
  output vram_tag_t tag_out
);

  vram_tag_t stage [DEPTH];

  // Clearing every stage drops all in-flight reads, so none of them can respond.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// Two-port arbiter for the single videoram read port, with response routing by tag.
// Define VRAM_RR_EN for round-robin arbitration; the default is fixed priority with a starvation guard.
module vram_read_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] vram_address,
  output logic              vram_chipselect,
  output logic              vram_clken,
  input  logic [DATA_W-1:0] vram_readdata
);

  logic              grant0;
  logic              grant1;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  vram_tag_t         tag_in;
  vram_tag_t         tag_out;

`ifdef VRAM_RR_EN
  // last_grant = 1 means port 1 won last, so port 0 wins the first contested cycle.
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant1 = req1_valid && (!req0_valid || !last_grant);
      grant0 = req0_valid && !grant1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset)       last_grant <= 1'b1;
    else if (grant0) last_grant <= 1'b0;
    else if (grant1) last_grant <= 1'b1;
  end
`else
  logic [3:0] starve_cnt;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant1 = req1_valid && (!req0_valid || (starve_cnt == 4'(STARVE_MAX)));
      grant0 = req0_valid && !grant1;
    end
  end

  // Counts port-0 wins while port 1 is waiting; saturates at STARVE_MAX because port 1 then wins.
  always_ff @(posedge sys_clk) begin
    if (reset || !req1_valid || grant1) starve_cnt <= '0;
    else if (grant0)                    starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  assign grant = grant0 || grant1;

  assign req0_ready      = grant0;
  assign req1_ready      = grant1;
  assign vram_chipselect = grant;
  assign vram_clken      = 1'b1;
  assign vram_address    = grant1 ? req1_addr :
                           grant0 ? req0_addr : addr_q;

  always_ff @(posedge sys_clk) begin
    if (reset)      addr_q <= ADDR_W'(VRAM_DEFAULT_ADDR);
    else if (grant) addr_q <= vram_address;
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant;
    tag_in.id    = ID_W'(grant1);
  end

  vram_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_tag_pipe (
    .clk     (sys_clk),
    .clear   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rsp0_valid = tag_out.valid && (tag_out.id == ID_W'(0));
  assign rsp1_valid = tag_out.valid && (tag_out.id == ID_W'(1));
  assign rsp_data   = tag_out.valid ? vram_readdata : '0;

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Directed bench for vram_read_arbiter with a 2-cycle registered videoram model.
module tb_vram_read_arbiter;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [11:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic [11:0] vram_address;
  logic        vram_chipselect, vram_clken;
  logic [31:0] vram_readdata;

  int checks = 0;
  int errors = 0;

  vram_read_arbiter dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .req0_valid      (req0_valid),
    .req0_addr       (req0_addr),
    .req0_ready      (req0_ready),
    .rsp0_valid      (rsp0_valid),
    .req1_valid      (req1_valid),
    .req1_addr       (req1_addr),
    .req1_ready      (req1_ready),
    .rsp1_valid      (rsp1_valid),
    .rsp_data        (rsp_data),
    .vram_address    (vram_address),
    .vram_chipselect (vram_chipselect),
    .vram_clken      (vram_clken),
    .vram_readdata   (vram_readdata)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  // Memory: address registered, then output registered -> data two cycles after issue.
  logic [11:0] rd_q1, rd_q2;
  always @(posedge sys_clk) begin
    rd_q1 <= vram_address;
    rd_q2 <= rd_q1;
  end
  assign vram_readdata = mem_word(rd_q2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    next();
    next();
    reset = 1'b0;
  endtask

  logic        exp_v0 [56];
  logic        exp_v1 [56];
  logic [31:0] exp_d  [56];
  logic [11:0] b2b    [3];
  logic [11:0] ea;
  logic        p1;
  logic        cs_seen;
  int          n0, n1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr = '0;
    req1_addr = '0;
    next();
    next();
    @(negedge sys_clk);
    check("rst_rsp0", rsp0_valid, 0);
    check("rst_rsp1", rsp1_valid, 0);
    check("rst_cs", vram_chipselect, 0);
    check("rst_data", rsp_data, 0);
    check("rst_addr", vram_address, 0);
    check("rst_clken", vram_clken, 1);
    next();
    reset = 1'b0;

    // Idle: chipselect must never assert.
    cs_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (vram_chipselect !== 1'b0) cs_seen = 1'b1;
      next();
    end
    check("idle_cs_seen", cs_seen, 0);
    @(negedge sys_clk);
    check("idle_ready0", req0_ready, 0);
    check("idle_ready1", req1_ready, 0);
    check("idle_rsp0", rsp0_valid, 0);
    check("idle_rsp1", rsp1_valid, 0);
    check("idle_data", rsp_data, 0);
    check("idle_addr", vram_address, 0);
    check("idle_clken", vram_clken, 1);
    next();

    // Single port-0 read.
    req0_valid = 1'b1;
    req0_addr = 12'h123;
    @(negedge sys_clk);
    check("p0_ready0", req0_ready, 1);
    check("p0_ready1", req1_ready, 0);
    check("p0_cs", vram_chipselect, 1);
    check("p0_addr", vram_address, 12'h123);
    next();
    req0_valid = 1'b0;
    req0_addr = 12'h777;
    @(negedge sys_clk);
    check("p0_cs_off", vram_chipselect, 0);
    check("p0_addr_hold", vram_address, 12'h123);
    check("p0_rsp_early", rsp0_valid, 0);
    next();
    @(negedge sys_clk);
    check("p0_rsp0", rsp0_valid, 1);
    check("p0_rsp1", rsp1_valid, 0);
    check("p0_data", rsp_data, mem_word(12'h123));
    next();
    @(negedge sys_clk);
    check("p0_rsp0_done", rsp0_valid, 0);
    check("p0_data_zero", rsp_data, 0);
    next();

    // Both ports valid for 48 cycles.
    reset_dut();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 56; i++) begin
      exp_v0[i] = 1'b0;
      exp_v1[i] = 1'b0;
      exp_d[i]  = '0;
    end
    for (int i = 0; i < 50; i++) begin
      if (i < 48) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr = 12'h100 + 12'(n0);
        req1_addr = 12'h800 + 12'(n1);
      end else begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge sys_clk);
      if (i < 48) begin
`ifdef VRAM_RR_EN
        p1 = (i % 2) == 1;
`else
        p1 = (i % 16) == 15;
`endif
        ea = p1 ? (12'h800 + 12'(n1)) : (12'h100 + 12'(n0));
        check("arb_ready0", req0_ready, !p1);
        check("arb_ready1", req1_ready, p1);
        check("arb_addr", vram_address, ea);
        exp_v0[i+2] = !p1;
        exp_v1[i+2] = p1;
        exp_d[i+2]  = mem_word(ea);
        if (p1) n1++;
        else    n0++;
      end
      check("arb_rsp0", rsp0_valid, exp_v0[i]);
      check("arb_rsp1", rsp1_valid, exp_v1[i]);
      check("arb_data", rsp_data, exp_d[i]);
      next();
    end

    // Back-to-back port-1 reads.
    b2b[0] = 12'h000;
    b2b[1] = 12'hFFF;
    b2b[2] = 12'h001;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        req1_valid = 1'b1;
        req1_addr = b2b[i];
      end else begin
        req1_valid = 1'b0;
      end
      @(negedge sys_clk);
      if (i < 3) begin
        check("b2b_ready1", req1_ready, 1);
        check("b2b_addr", vram_address, b2b[i]);
      end
      if (i >= 2 && i < 5) begin
        check("b2b_rsp1", rsp1_valid, 1);
        check("b2b_data", rsp_data, mem_word(b2b[i-2]));
      end else begin
        check("b2b_rsp1_idle", rsp1_valid, 0);
      end
      check("b2b_rsp0", rsp0_valid, 0);
      next();
    end

    // Reset one cycle after a grant drops the in-flight read.
    req0_valid = 1'b1;
    req0_addr = 12'h2AB;
    @(negedge sys_clk);
    check("mrst_ready0", req0_ready, 1);
    next();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_addr = 12'h3CD;
    reset = 1'b1;
    @(negedge sys_clk);
    check("mrst_ready1", req1_ready, 0);
    check("mrst_cs", vram_chipselect, 0);
    next();
    reset = 1'b0;
    req1_valid = 1'b0;
    @(negedge sys_clk);
    check("mrst_rsp0", rsp0_valid, 0);
    check("mrst_rsp1", rsp1_valid, 0);
    check("mrst_data", rsp_data, 0);
    next();
    @(negedge sys_clk);
    check("mrst_rsp0_late", rsp0_valid, 0);
    next();
    req0_valid = 1'b1;
    req0_addr = 12'h3CD;
    @(negedge sys_clk);
    check("post_ready0", req0_ready, 1);
    next();
    req0_valid = 1'b0;
    next();
    @(negedge sys_clk);
    check("post_rsp0", rsp0_valid, 1);
    check("post_data", rsp_data, mem_word(12'h3CD));
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
